// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// if_fetch_stage : MIPS fetch stage with IF/ID register, ID-resolved redirect.
// Rev 1.0
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [1:0]         br_sel,
    input  logic               cmp_eq,
    input  logic [31:0]        jr_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               redirect
);

    localparam logic [1:0] c_BR_4   = 2'b00;
    localparam logic [1:0] c_BR_BEQ = 2'b01;
    localparam logic [1:0] c_BR_JAL = 2'b10;
    localparam logic [1:0] c_BR_JR  = 2'b11;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        r_valid;

    logic [31:0] w_pc4;
    logic [31:0] w_target;
    logic        w_cond;
    logic        w_take;

    assign w_pc4 = r_pc + 32'd4;

    // Operands seen in ID are stale while stalled, so a stall masks the redirect.
    always_comb begin
        w_cond   = 1'b0;
        w_target = r_id_pc4;
        case (br_sel)
            c_BR_BEQ: begin
                w_cond   = cmp_eq;
                w_target = r_id_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
            end
            c_BR_JAL: begin
                w_cond   = 1'b1;
                w_target = {r_id_pc4[31:28], r_instr[25:0], 2'b00};
            end
            c_BR_JR: begin
                w_cond   = 1'b1;
                w_target = {jr_target[31:2], 2'b00};
            end
            default: begin
                w_cond   = 1'b0;
                w_target = r_id_pc4;
            end
        endcase
    end

    assign w_take = r_valid & ~stall & w_cond;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_id_pc  <= 32'd0;
            r_id_pc4 <= 32'd0;
            r_valid  <= 1'b0;
        end else if (stall) begin
            r_pc     <= r_pc;
            r_instr  <= r_instr;
            r_id_pc  <= r_id_pc;
            r_id_pc4 <= r_id_pc4;
            r_valid  <= r_valid;
        end else if (w_take) begin
            // No delay slot: the word fetched this cycle is squashed into a bubble.
            r_pc     <= w_target;
            r_instr  <= 32'd0;
            r_id_pc  <= r_pc;
            r_id_pc4 <= w_pc4;
            r_valid  <= 1'b0;
        end else begin
            r_pc     <= w_pc4;
            r_instr  <= imem_rdata;
            r_id_pc  <= r_pc;
            r_id_pc4 <= w_pc4;
            r_valid  <= 1'b1;
        end
    end

    assign imem_addr   = r_pc[IMEM_AW+1:2];
    assign pc          = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_id_pc;
    assign if_id_pc4   = r_id_pc4;
    assign if_id_valid = r_valid;
    assign redirect    = w_take;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// Directed bench for if_fetch_stage: fetch, beq/jal/jr redirects, stall, async reset.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  br_sel;
    logic        cmp_eq;
    logic [31:0] jr_target;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        redirect;

    logic [31:0] mem [1024];
    int          n_checks;
    int          n_errors;

    if_fetch_stage #(
        .RESET_PC (32'h0000_3000),
        .IMEM_AW  (10)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_sel      (br_sel),
        .cmp_eq      (cmp_eq),
        .jr_target   (jr_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .redirect    (redirect)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc",    pc,                  32'h0000_3000);
        chk("rst_instr", if_id_instr,         32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_redir", {31'd0, redirect},    32'd0);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
        mem[1] = 32'h1000_0003;   // beq $0,$0,+3 at 0x3004
        mem[3] = 32'h0C00_0C10;   // jal 0x0C10 at 0x300C
        reset = 1'b0; stall = 1'b0; br_sel = 2'b00; cmp_eq = 1'b0; jr_target = 32'h0;
        n_checks = 0; n_errors = 0;

        // Sequential fetch then taken beq
        do_reset();
        chk("rst_pc4",   if_id_pc4, 32'h0);
        step();
        chk("seq_pc1",   pc,          32'h0000_3004);
        chk("seq_ins1",  if_id_instr, 32'h0000_1000);
        chk("seq_idpc1", if_id_pc,    32'h0000_3000);
        chk("seq_val1",  {31'd0, if_id_valid}, 32'd1);
        step();
        chk("seq_pc2",   pc,          32'h0000_3008);
        chk("seq_ins2",  if_id_instr, 32'h1000_0003);
        chk("seq_pc4_2", if_id_pc4,   32'h0000_3008);
        br_sel = 2'b01; cmp_eq = 1'b1; #1;
        chk("beq_redir", {31'd0, redirect}, 32'd1);
        step();
        chk("beq_pc",    pc,          32'h0000_3014);
        chk("beq_val",   {31'd0, if_id_valid}, 32'd0);
        chk("beq_ins",   if_id_instr, 32'h0);
        chk("beq_idpc",  if_id_pc,    32'h0000_3008);
        br_sel = 2'b10; #1;
        chk("bub_noredir", {31'd0, redirect}, 32'd0);
        br_sel = 2'b00; cmp_eq = 1'b0;
        step();
        chk("beq_pc2",   pc,          32'h0000_3018);
        chk("beq_ins2",  if_id_instr, 32'h0000_1005);
        chk("beq_val2",  {31'd0, if_id_valid}, 32'd1);

        // Untaken beq, jal, jr with misaligned target
        do_reset();
        step();
        step();
        br_sel = 2'b01; cmp_eq = 1'b0; #1;
        chk("nbeq_redir", {31'd0, redirect}, 32'd0);
        step();
        chk("nbeq_pc",   pc,          32'h0000_300C);
        chk("nbeq_ins",  if_id_instr, 32'h0000_1002);
        br_sel = 2'b00;
        step();
        chk("jal_idpc4", if_id_pc4,   32'h0000_3010);
        chk("jal_ins",   if_id_instr, 32'h0C00_0C10);
        br_sel = 2'b10; #1;
        chk("jal_redir", {31'd0, redirect}, 32'd1);
        step();
        chk("jal_pc",    pc,          32'h0000_3040);
        chk("jal_val",   {31'd0, if_id_valid}, 32'd0);
        chk("jal_bpc4",  if_id_pc4,   32'h0000_3014);
        br_sel = 2'b00;
        step();
        chk("jr_ins",    if_id_instr, 32'h0000_1010);
        br_sel = 2'b11; jr_target = 32'h0000_3103; #1;
        chk("jr_redir",  {31'd0, redirect}, 32'd1);
        step();
        chk("jr_pc",     pc,          32'h0000_3100);
        chk("jr_val",    {31'd0, if_id_valid}, 32'd0);
        chk("jr_idpc",   if_id_pc,    32'h0000_3044);
        br_sel = 2'b00;
        step();
        chk("jr_ins2",   if_id_instr, 32'h0000_1040);
        chk("jr_pc2",    pc,          32'h0000_3104);

        // Stall masks redirect; release lets it fire; async reset mid-stall
        do_reset();
        step();
        step();
        stall = 1'b1; br_sel = 2'b01; cmp_eq = 1'b1; #1;
        chk("stl_redir", {31'd0, redirect}, 32'd0);
        repeat (2) step();
        chk("stl_pc",    pc,          32'h0000_3008);
        chk("stl_idpc",  if_id_pc,    32'h0000_3004);
        chk("stl_ins",   if_id_instr, 32'h1000_0003);
        chk("stl_val",   {31'd0, if_id_valid}, 32'd1);
        chk("stl_redir2", {31'd0, redirect}, 32'd0);
        stall = 1'b0; #1;
        chk("stl_rel_redir", {31'd0, redirect}, 32'd1);
        step();
        chk("stl_rel_pc", pc, 32'h0000_3014);
        br_sel = 2'b00; cmp_eq = 1'b0;
        step();
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc",  pc, 32'h0000_3000);
        chk("async_val", {31'd0, if_id_valid}, 32'd0);
        chk("async_ins", if_id_instr, 32'h0);
        stall = 1'b0;

        // PC wrap past 0xFFFF_FFFC
        do_reset();
        step();
        br_sel = 2'b11; jr_target = 32'hFFFF_FFFC;
        step();
        chk("wrap_pc0",  pc, 32'hFFFF_FFFC);
        chk("wrap_addr", {22'd0, imem_addr}, 32'h0000_03FF);
        br_sel = 2'b00;
        step();
        chk("wrap_pc1",  pc,        32'h0);
        chk("wrap_pc4",  if_id_pc4, 32'h0);
        chk("wrap_ins",  if_id_instr, 32'h0000_13FF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word into IF/ID for the decode-stage controller.
- Resolves the next PC from the controller's Br select (Br_4/Br_beq/Br_jal/Br_jr), evaluated in ID, and applies hazard-unit stall and branch flush.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset (text-segment base)
IMEM_AW, 10, instruction-memory word-address width (1K words)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hazard-unit stall; holds PC and IF/ID
br_sel  input  2  Br from the ID-stage controller: 00 Br_4, 01 Br_beq, 10 Br_jal, 11 Br_jr
cmp_eq  input  1  ID-stage comparator, rs==rt (forwarded values)
jr_target  input  32  ID-stage forwarded rs value
imem_addr  output  IMEM_AW  word address to instruction memory, = pc[IMEM_AW+1:2]
imem_rdata  input  32  combinational instruction-memory read data for imem_addr
pc  output  32  current fetch PC
if_id_instr  output  32  instruction presented to ID (decoder input)
if_id_pc  output  32  PC of the ID instruction
if_id_pc4  output  32  if_id_pc+4, used for jal link (ToReg_NPC)
if_id_valid  output  1  ID slot holds a real instruction (0 = bubble)
redirect  output  1  next PC is a taken control transfer this cycle

Behaviour:
Reset (reset==0, asynchronous, dominates everything):
- pc=RESET_PC; if_id_instr=0 (nop); if_id_pc=0; if_id_pc4=0; if_id_valid=0; redirect=0.
- Reset released mid-operation: fetch restarts at RESET_PC; all in-flight state is discarded.

Combinational decode of the ID instruction:
- take = if_id_valid & ~stall & ((br_sel==01 & cmp_eq) | br_sel==10 | br_sel==11).
- redirect = take. Stall suppresses redirect because ID operands are stale while stalled.
- Target when br_sel==01: if_id_pc4 + {{14{imm[15]}}, imm, 2'b00}, where imm = if_id_instr[15:0].
- Target when br_sel==10: {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
- Target when br_sel==11: {jr_target[31:2], 2'b00}. Low two bits are dropped; no exception.
- All adds are 32-bit modulo 2^32; pc+4 from 32'hFFFF_FFFC wraps to 0.
- No branch delay slot: the instruction fetched behind a taken transfer is squashed.

Per rising edge, in priority order:
1. stall==1: pc, if_id_instr, if_id_pc, if_id_pc4 and if_id_valid all hold; imem_addr is unchanged.
2. take==1:
   - pc <= target.
   - IF/ID <= bubble: instr=0, valid=0, pc fields <= pc / pc+4 of the squashed fetch.
3. Otherwise:
   - pc <= pc+4.
   - if_id_instr <= imem_rdata; if_id_pc <= pc; if_id_pc4 <= pc+4; if_id_valid <= 1.

Other rules:
- Fetch latency: the instruction at PC X appears on if_id_instr one cycle after pc==X, absent stall or flush.
- A bubble (valid=0) never redirects, even if a stale br_sel is decoded from it; instr 0 decodes as sll nop.
- Back-to-back taken transfers are legal: each one squashes exactly one slot.
- Branch to self (imm = 16'hFFFF): steady loop with alternating valid/bubble slots.
- imem_rdata is sampled only in case 3.

Test Plan:
- Reset and sequential fetch: reset low 3 cycles, then release; imem holds 32'h1000+i at word i → pc 3000, 3004, 3008; if_id_instr trails pc by one cycle; if_id_valid rises 1 cycle after release.
- Taken beq: beq (imm=16'h0003) at 3004, cmp_eq=1 → next pc = 3008+0xC = 3014; slot fetched from 3008 becomes bubble (valid=0); then 3014's instr appears.
- Untaken beq and jal: beq with cmp_eq=0 → no redirect, pc continues 3008, 300C. jal 26'h0000C10 at 300C → pc=3040, if_id_pc4=3010 held while jal is in ID.
- jr with misaligned target: jr_target=32'h0000_3103 → pc=3100; one bubble inserted.
- Stall vs. redirect and reset mid-run: stall=1 for 2 cycles while a taken beq sits in ID → pc and IF/ID frozen, redirect=0; on stall release the redirect fires. Assert reset mid-stall → pc=3000 and valid=0 immediately, without waiting for a clock edge.
